recip_divide_seq: RTL and testbench
===================================

# recip_divide_seq

Fixed-point divide sequencer that computes Numerator / Denominator by obtaining 1/|Denominator| from the reciprocal CORDIC stage and multiplying it by Numerator. It sits directly around that stage: upstream, it issues the one-cycle start pulse and operand; downstream, it consumes the reciprocal result and Valid strobe. Callers get a valid/ready handshake, sign handling, zero-divisor detection and saturation. It has one operation in flight at a time.

## Interface
- WORD_LENGTH, 18, total bits of all fixed-point words (two's complement)
- FRAC_LENGTH, 11, fractional bits; 1.0 = 2^FRAC_LENGTH
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept; high only in IDLE
- Numerator  in  WORD_LENGTH  signed dividend
- Denominator  in  WORD_LENGTH  signed divisor
- rc_enable  out  1  one-cycle start pulse to reciprocal stage
- rc_input  out  WORD_LENGTH  |Denominator| to reciprocal stage; held stable from LAUNCH through WAIT
- rc_reciprocal  in  WORD_LENGTH  reciprocal result
- rc_valid  in  1  reciprocal result strobe
- out_valid  out  1  quotient available
- out_ready  in  1  consumer accepts quotient
- Quotient  out  WORD_LENGTH  signed saturated result
- div_by_zero  out  1  qualifies Quotient; high when Denominator was 0

## Operation
- **Reset values:** all outputs 0 except in_ready = 1. State is IDLE.
- **States:** IDLE, LAUNCH, WAIT, MUL, OUT.
- **IDLE:**
  - in_ready = 1.
  - On in_valid, register Numerator, |Denominator| and neg = sign(N) xor sign(D).
  - |D| of the most negative value saturates to 2^(W-1)-1.
  - If Denominator == 0, go to OUT with div_by_zero = 1. Quotient is max positive (2^(W-1)-1) if Numerator >= 0, otherwise min negative (-2^(W-1)).
  - Otherwise go to LAUNCH.
- **LAUNCH:** rc_enable = 1 for exactly this cycle; go to WAIT.
- **WAIT:**
  - On rc_valid = 1, capture rc_reciprocal into recip_q and go to MUL.
  - rc_valid is ignored in every other state.
- **MUL:**
  - Form the 2*WORD_LENGTH-bit signed product Numerator_abs * recip_q.
  - Shift right by FRAC_LENGTH, then apply neg.
  - Saturate to WORD_LENGTH bits and register into Quotient.
  - Set out_valid = 1 and go to OUT.
- **OUT:**
  - Quotient and div_by_zero are held stable while out_valid = 1 and out_ready = 0.
  - On out_ready = 1, clear out_valid and go to IDLE.
- **Arithmetic:** magnitude path throughout; the sign is applied after the shift, so rounding is symmetric about zero.
- **Reset mid-operation:** returns to IDLE on the next edge. rc_enable is low, so any later rc_valid from the stage is ignored.

## Timing
- Accept edge t0: in_valid && in_ready.
- rc_enable is high in cycle t0+1.
- If rc_valid is high in cycle c, out_valid rises at cycle c+2.
- Zero divisor: out_valid rises at t0+1; the reciprocal stage is never started.
- Throughput: one operation per (reciprocal latency + 4) cycles.
- Back-to-back: when out_ready is high in the first OUT cycle, in_ready returns the next cycle.
- No combinational path from in_valid or out_ready to any output.

## Configuration
- RECIP_DIV_ROUND_EN defined: MUL adds 2^(FRAC_LENGTH-1) to the magnitude product before the shift (round half away from zero).
- RECIP_DIV_ROUND_EN undefined: truncation toward zero.
- Latency is identical in both builds.

## Structure
- Shared package `recip_div_pkg`:
  - state enum
  - function computing the saturation limits from WORD_LENGTH
  - ONE constant (1 << FRAC_LENGTH)
- One sub-module, `recip_div_mulsat`: registered-input combinational multiply, optional round, shift, sign and saturate. The FSM lives in the top module.

## Test plan
All scenarios use W=18, F=11, with a bench stub for the reciprocal stage that returns a given value 13 cycles after rc_enable.

- **Basic divide:** N=6144 (3.0), D=4096 (2.0), stub returns 1024 → Quotient = 3072; out_valid exactly 2 cycles after rc_valid; rc_enable high for 1 cycle with rc_input = 4096.
- **Sign handling:** N=-6144, D=4096, stub returns 1024 → Quotient = -3072. N=-6144, D=-4096 → rc_input = 4096, Quotient = +3072.
- **Zero divisor:**
  - N=-2048, D=0 → out_valid at t0+1, Quotient = -131072, div_by_zero = 1, rc_enable never asserted.
  - N=0, D=0 → Quotient = 131071.
- **Saturation:** N=122880 (60.0), D=512, stub returns 8192 → Quotient = 131071. Same with N=-122880 → Quotient = -131072.
- **Backpressure and rounding:**
  - Hold out_ready = 0 for 10 cycles: Quotient stable, in_ready = 0, rc_valid pulses ignored.
  - N=3, stub 1024: Quotient = 2 with RECIP_DIV_ROUND_EN, 1 without.
- **Reset mid-WAIT:** assert RST, then the stub fires rc_valid → no out_valid; in_ready = 1 the cycle after RST deasserts.

Source files
------------

// File: rtl/recip_div_pkg.sv
// Shared types and helpers for the reciprocal-based divide sequencer.
package recip_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_MUL,
    ST_OUT
  } state_t;

  localparam int DEFAULT_FRAC_LENGTH = 11;
  localparam int ONE = 1 << DEFAULT_FRAC_LENGTH;

  // Two's-complement limits of a w-bit word, widened so callers can size-cast.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/recip_div_mulsat.sv
// Magnitude multiply by the reciprocal, optional rounding (RECIP_DIV_ROUND_EN),
// shift, sign restore and saturation. Purely combinational; inputs are registers.
module recip_div_mulsat
  import recip_div_pkg::*;
#(
  parameter int WORD_LENGTH = 18,
  parameter int FRAC_LENGTH = 11
) (
  input  logic [WORD_LENGTH-1:0]        num_abs,
  input  logic signed [WORD_LENGTH-1:0] recip,
  input  logic                          neg,
  output logic signed [WORD_LENGTH-1:0] quotient
);

  // Two guard bits: the magnitude of the most negative numerator needs W unsigned bits.
  localparam int PW = 2 * WORD_LENGTH + 2;
  localparam logic signed [PW-1:0] Q_MAX = PW'(sat_max(WORD_LENGTH));
  localparam logic signed [PW-1:0] Q_MIN = PW'(sat_min(WORD_LENGTH));
  localparam logic signed [PW-1:0] HALF  = PW'(1) <<< (FRAC_LENGTH - 1);

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] biased;
  logic signed [PW-1:0] shifted;
  logic signed [PW-1:0] signed_val;

  always_comb begin
    prod = $signed({{(PW - WORD_LENGTH){1'b0}}, num_abs}) *
           $signed({{(PW - WORD_LENGTH){recip[WORD_LENGTH-1]}}, recip});
`ifdef RECIP_DIV_ROUND_EN
    biased = prod + HALF;
`else
    biased = prod;
`endif
    shifted    = biased >>> FRAC_LENGTH;
    signed_val = neg ? -shifted : shifted;
    if (signed_val > Q_MAX) begin
      quotient = Q_MAX[WORD_LENGTH-1:0];
    end else if (signed_val < Q_MIN) begin
      quotient = Q_MIN[WORD_LENGTH-1:0];
    end else begin
      quotient = signed_val[WORD_LENGTH-1:0];
    end
  end

endmodule

// File: rtl/recip_divide_seq.sv
// Divide sequencer around a reciprocal CORDIC stage: Quotient = N * (1/|D|) with sign,
// zero-divisor and saturation handling. RECIP_DIV_ROUND_EN selects rounding over truncation.
module recip_divide_seq
  import recip_div_pkg::*;
#(
  parameter int WORD_LENGTH = 18,
  parameter int FRAC_LENGTH = 11
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WORD_LENGTH-1:0] Numerator,
  input  logic signed [WORD_LENGTH-1:0] Denominator,
  output logic                          rc_enable,
  output logic [WORD_LENGTH-1:0]        rc_input,
  input  logic signed [WORD_LENGTH-1:0] rc_reciprocal,
  input  logic                          rc_valid,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WORD_LENGTH-1:0] Quotient,
  output logic                          div_by_zero
);

  localparam logic signed [WORD_LENGTH-1:0] Q_MAX = WORD_LENGTH'(sat_max(WORD_LENGTH));
  localparam logic signed [WORD_LENGTH-1:0] Q_MIN = WORD_LENGTH'(sat_min(WORD_LENGTH));

  state_t                          state_reg;
  logic [WORD_LENGTH-1:0]          num_abs_reg;
  logic signed [WORD_LENGTH-1:0]   recip_reg;
  logic                            neg_reg;
  logic [WORD_LENGTH-1:0]          abs_n;
  logic [WORD_LENGTH-1:0]          abs_d;
  logic signed [WORD_LENGTH-1:0]   mul_q;

  // |D| of the most negative divisor saturates; |N| keeps full unsigned magnitude.
  always_comb begin
    abs_n = Numerator[WORD_LENGTH-1] ? (~Numerator + 1'b1) : Numerator;
    if (Denominator == Q_MIN) begin
      abs_d = Q_MAX;
    end else begin
      abs_d = Denominator[WORD_LENGTH-1] ? (~Denominator + 1'b1) : Denominator;
    end
  end

  recip_div_mulsat #(
    .WORD_LENGTH(WORD_LENGTH),
    .FRAC_LENGTH(FRAC_LENGTH)
  ) u_mulsat (
    .num_abs (num_abs_reg),
    .recip   (recip_reg),
    .neg     (neg_reg),
    .quotient(mul_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      in_ready    <= 1'b1;
      rc_enable   <= 1'b0;
      rc_input    <= '0;
      out_valid   <= 1'b0;
      Quotient    <= '0;
      div_by_zero <= 1'b0;
      num_abs_reg <= '0;
      recip_reg   <= '0;
      neg_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            num_abs_reg <= abs_n;
            neg_reg     <= Numerator[WORD_LENGTH-1] ^ Denominator[WORD_LENGTH-1];
            rc_input    <= abs_d;
            if (Denominator == '0) begin
              Quotient    <= Numerator[WORD_LENGTH-1] ? Q_MIN : Q_MAX;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state_reg   <= ST_OUT;
            end else begin
              div_by_zero <= 1'b0;
              rc_enable   <= 1'b1;
              state_reg   <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          rc_enable <= 1'b0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rc_valid) begin
            recip_reg <= rc_reciprocal;
            state_reg <= ST_MUL;
          end
        end
        ST_MUL: begin
          Quotient  <= mul_q;
          out_valid <= 1'b1;
          state_reg <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_divide_seq.sv
// Self-checking bench for recip_divide_seq with a fixed-latency reciprocal stub.
module tb_recip_divide_seq;
  import recip_div_pkg::*;

  localparam int W = 18;
  localparam int F = 11;
  localparam longint QMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint QMIN = -(longint'(1) <<< (W - 1));

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [W-1:0]  Numerator = '0;
  logic signed [W-1:0]  Denominator = '0;
  logic                 rc_enable;
  logic [W-1:0]         rc_input;
  logic signed [W-1:0]  rc_reciprocal;
  logic                 rc_valid;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [W-1:0]  Quotient;
  logic                 div_by_zero;

  logic [W-1:0] stub_val = '0;
  logic         extra_rv = 1'b0;
  int           stub_cnt = 0;

  int n_cmp  = 0;
  int n_miss = 0;

  recip_divide_seq #(.WORD_LENGTH(W), .FRAC_LENGTH(F)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .Numerator(Numerator), .Denominator(Denominator),
    .rc_enable(rc_enable), .rc_input(rc_input),
    .rc_reciprocal(rc_reciprocal), .rc_valid(rc_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .Quotient(Quotient), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  // Reciprocal stage stand-in: strobes its value 13 cycles after the start pulse.
  always @(posedge CLK) begin
    if (rc_enable) stub_cnt <= 13;
    else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
  end
  assign rc_valid      = (stub_cnt == 1) || extra_rv;
  assign rc_reciprocal = stub_val;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_q(input longint n, input longint d, input longint r);
    longint mag, p, q;
    if (d == 0) return (n < 0) ? QMIN : QMAX;
    mag = (n < 0) ? -n : n;
    p   = mag * r;
`ifdef RECIP_DIV_ROUND_EN
    p = p + ONE / 2;
`endif
    q = p / ONE;
    if ((n < 0) != (d < 0)) q = -q;
    if (q > QMAX) q = QMAX;
    if (q < QMIN) q = QMIN;
    return q;
  endfunction

  function automatic longint ref_abs_d(input longint d);
    if (d == QMIN) return QMAX;
    return (d < 0) ? -d : d;
  endfunction

  typedef struct {
    logic signed [W-1:0] n;
    logic signed [W-1:0] d;
    logic [W-1:0]        r;
    int                  hold;
    logic signed [W-1:0] exp_q;
    logic                exp_dbz;
    logic [W-1:0]        exp_rcin;
  } vec_t;

  function automatic vec_t mk(input int n, input int d, input int r, input int hold,
                              input int q, input int dbz, input int rcin);
    vec_t v;
    v.n = W'(n); v.d = W'(d); v.r = W'(r); v.hold = hold;
    v.exp_q = W'(q); v.exp_dbz = dbz[0]; v.exp_rcin = W'(rcin);
    return v;
  endfunction

  task automatic do_op(input logic signed [W-1:0] n, input logic signed [W-1:0] d,
                       input logic [W-1:0] r, input int hold,
                       output logic signed [W-1:0] q, output logic dbz,
                       output int en_cnt, output int en_cyc, output int rv_cyc,
                       output int ov_cyc, output logic [W-1:0] rc_in);
    @(negedge CLK);
    chk("in_ready_idle", in_ready, 1);
    Numerator = n; Denominator = d; stub_val = r; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    en_cnt = 0; en_cyc = -1; rv_cyc = -1; ov_cyc = -1; rc_in = '0;
    for (int k = 1; k <= 40 && ov_cyc < 0; k++) begin
      @(negedge CLK);
      if (rc_enable) begin en_cnt++; en_cyc = k; rc_in = rc_input; end
      if (rc_valid && rv_cyc < 0) rv_cyc = k;
      if (out_valid) ov_cyc = k;
    end
    chk("out_valid_seen", (ov_cyc > 0), 1);
    q = Quotient; dbz = div_by_zero;
    for (int h = 0; h < hold; h++) begin
      extra_rv = (h == 3);
      @(negedge CLK);
      extra_rv = 1'b0;
      chk("hold_quotient", Quotient, q);
      chk("hold_dbz", div_by_zero, dbz);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    chk("in_ready_after_out", in_ready, 1);
    chk("out_valid_cleared", out_valid, 0);
  endtask

  task automatic check_result(input string tag, input vec_t v);
    logic signed [W-1:0] q;
    logic dbz;
    int en_cnt, en_cyc, rv_cyc, ov_cyc;
    logic [W-1:0] rc_in;
    do_op(v.n, v.d, v.r, v.hold, q, dbz, en_cnt, en_cyc, rv_cyc, ov_cyc, rc_in);
    $display("%s: N=%0d D=%0d recip=%0d -> Q=%0d dbz=%0d", tag, v.n, v.d, v.r, q, dbz);
    chk({tag, "_quotient"}, q, v.exp_q);
    chk({tag, "_dbz"}, dbz, v.exp_dbz);
    if (v.exp_dbz) begin
      chk({tag, "_no_enable"}, en_cnt, 0);
      chk({tag, "_zero_latency"}, ov_cyc, 1);
    end else begin
      chk({tag, "_enable_count"}, en_cnt, 1);
      chk({tag, "_enable_cycle"}, en_cyc, 1);
      chk({tag, "_rc_input"}, rc_in, v.exp_rcin);
      chk({tag, "_out_latency"}, ov_cyc, rv_cyc + 2);
    end
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    int   ov_seen;
    int   rnd_n, rnd_d, rnd_r;
    int   round_q;

`ifdef RECIP_DIV_ROUND_EN
    round_q = 2;
`else
    round_q = 1;
`endif
    tbl[0] = mk(6144, 4096, 1024, 0, 3072, 0, 4096);
    tbl[1] = mk(-6144, 4096, 1024, 0, -3072, 0, 4096);
    tbl[2] = mk(-6144, -4096, 1024, 0, 3072, 0, 4096);
    tbl[3] = mk(-2048, 0, 0, 0, -131072, 1, 0);
    tbl[4] = mk(0, 0, 0, 0, 131071, 1, 0);
    tbl[5] = mk(122880, 512, 8192, 0, 131071, 0, 512);
    tbl[6] = mk(-122880, 512, 8192, 0, -131072, 0, 512);
    tbl[7] = mk(3, 2048, 1024, 10, round_q, 0, 2048);
    tbl[8] = mk(-2048, 0, 0, 10, -131072, 1, 0);
    tbl[9] = mk(100, -131072, 2048, 0, -100, 0, 131071);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rc_enable", rc_enable, 0);
    chk("reset_rc_input", rc_input, 0);
    chk("reset_quotient", Quotient, 0);
    chk("reset_dbz", div_by_zero, 0);
    RST = 1'b0;

    for (int i = 0; i < 10; i++) check_result($sformatf("vec%0d", i), tbl[i]);

    // Reset while waiting on the reciprocal; the late strobe must be ignored.
    @(negedge CLK);
    Numerator = 18'sd6144; Denominator = 18'sd4096; stub_val = 18'd1024; in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_in_ready", in_ready, 1);
    ov_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK);
      if (out_valid || rc_enable) ov_seen++;
    end
    $display("reset_mid_wait: out_valid/rc_enable cycles after reset = %0d", ov_seen);
    chk("rst_mid_no_output", ov_seen, 0);
    chk("rst_mid_in_ready_after", in_ready, 1);

    for (int i = 0; i < 40; i++) begin
      rnd_n = int'($signed(W'($urandom)));
      rnd_d = ($urandom_range(0, 7) == 0) ? 0 : int'($signed(W'($urandom)));
      rnd_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 131071))
                                          : int'($urandom_range(0, 4095));
      v = mk(rnd_n, rnd_d, rnd_r, (i % 8 == 5) ? 3 : 0,
             int'(ref_q(rnd_n, rnd_d, rnd_r)), (rnd_d == 0) ? 1 : 0,
             int'(ref_abs_d(rnd_d)));
      check_result($sformatf("rnd%0d", i), v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
